// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub/logic/shift, iterative shift-add multiply.
// Latency: 1 cycle for opcodes 0..6, WIDTH+1 cycles for MUL (accept to out_valid).
// Backpressure: result held stable in DONE until out_ready; in_ready follows out_ready there.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int             MSB      = WIDTH - 1;
    localparam logic [SW-1:0]  CNT_LAST = SW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic                 rdy_en_q;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [SW-1:0]        cnt_q, cnt_d;

    logic [SW-1:0]        sh_amt;
    logic [WIDTH:0]       add_w;
    logic [WIDTH:0]       sub_w;
    logic [2*WIDTH-1:0]   shl_w;
    logic [2*WIDTH-1:0]   shr_w;
    logic [2*WIDTH-1:0]   mul_acc_nxt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c;
    logic                 alu_v;
    logic                 accept;

    // Single-cycle datapath; shifts are done in a double-width window so the
    // last bit shifted out lands at a fixed position (0 when the amount is 0).
    always_comb begin
        sh_amt  = b[SW-1:0];
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} - {1'b0, b};
        shl_w   = {{WIDTH{1'b0}}, a} << sh_amt;
        shr_w   = {a, {WIDTH{1'b0}}} >> sh_amt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode)
            3'd0: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
            end
            3'd1: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
            end
            3'd2: alu_res = a & b;
            3'd3: alu_res = a | b;
            3'd4: alu_res = a ^ b;
            3'd5: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            3'd6: begin
                alu_res = shr_w[2*WIDTH-1:WIDTH];
                alu_c   = shr_w[WIDTH-1];
            end
            default: ;
        endcase
    end

    assign mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        // rdy_en_q keeps in_ready low through reset and until the first edge after release
        in_ready  = rdy_en_q && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
        out_valid = (state_q == S_DONE);
        accept    = in_valid && in_ready;

        case (state_q)
            S_MUL: begin
                acc_d    = mul_acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SW'(1);
                if (cnt_q == CNT_LAST) begin
                    out_d   = mul_acc_nxt[WIDTH-1:0];
                    carry_d = |mul_acc_nxt[2*WIDTH-1:WIDTH];
                    ovf_d   = 1'b0;
                    zero_d  = (mul_acc_nxt[WIDTH-1:0] == '0);
                    neg_d   = mul_acc_nxt[MSB];
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // Accept only happens in IDLE or DONE, so it never collides with the MUL step.
        if (accept) begin
            if (opcode == 3'd7) begin
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = S_MUL;
            end else begin
                out_d    = alu_res;
                carry_d  = alu_c;
                ovf_d    = alu_v;
                zero_d   = (alu_res == '0);
                neg_d    = alu_res[MSB];
                state_d  = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdy_en_q <= 1'b0;
            out_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            out_q    <= out_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;
    assign neg   = neg_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be a power of two, 4..64.
REQ-002 Parameter SW, default $clog2(WIDTH), shift-amount width; SHALL be derived from WIDTH, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 opcode  input  3  operation select (REQ-012).
REQ-008 a, b  input  WIDTH each  operands, unsigned unless stated.
REQ-009 out_valid  output  1  result registered and presented.
REQ-010 out_ready  input  1  downstream consumes result.
REQ-011 out [WIDTH], carry, ovf, zero, neg  outputs  result and flags, valid only while out_valid=1.

Function
REQ-012 Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 SHL a<<b[SW-1:0]; 6 SHR logical a>>b[SW-1:0]; 7 MUL low WIDTH bits of a*b.
REQ-013 Transfer in: in_valid & in_ready at rising edge; a, b, opcode captured that edge; inputs ignored otherwise.
REQ-014 Transfer out: out_valid & out_ready at rising edge; out and flags SHALL be stable while out_valid=1 and out_ready=0.
REQ-015 FSM states IDLE, MUL, DONE; reset state IDLE.
REQ-016 IDLE: in_ready=1; on accept of opcode 0..6 result registered that edge, next state DONE (latency 1 cycle); on accept of opcode 7 next state MUL; no accept -> stay IDLE.
REQ-017 MUL: iterative shift-add, one multiplier bit per cycle, exactly WIDTH cycles in MUL, then DONE (latency WIDTH+1 cycles accept-to-out_valid); in_ready=0.
REQ-018 DONE: out_valid=1; in_ready=out_ready; out_ready=0 -> stay DONE.
REQ-019 DONE with out_ready=1 and in_valid=1 (simultaneous): old result consumed and new operation accepted same edge; next state per REQ-016 (back-to-back throughput 1 op/cycle for opcodes 0..6).
REQ-020 DONE with out_ready=1, in_valid=0 -> IDLE, out_valid=0 next cycle.
REQ-021 ADD: carry=carry-out of WIDTH-bit sum; ovf=signed overflow (operand signs equal, result sign differs).
REQ-022 SUB: carry=borrow (1 iff a<b unsigned); ovf=signed overflow (operand signs differ, result sign differs from a).
REQ-023 SHL/SHR: carry=last bit shifted out; shift amount 0 -> out=a, carry=0; ovf=0.
REQ-024 MUL: carry=1 iff upper WIDTH bits of full 2*WIDTH product nonzero; ovf=0.
REQ-025 Logic ops (2,3,4): carry=0, ovf=0.
REQ-026 All ops: zero=(out==0); neg=out[WIDTH-1].
REQ-027 Operands SHALL be registered on accept; changes on a, b, opcode during MUL or DONE SHALL NOT affect the pending result.
REQ-028 No combinational path from in_valid to in_ready or out_valid; in_ready depends only on state and out_ready.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, out_valid=0, out=0, carry=ovf=zero=neg=0, multiplier accumulator/counter=0, independent of clk.
REQ-030 in_ready SHALL be 0 while rst_n=0 and 1 from first rising edge after deassertion.
REQ-031 Reset asserted mid-MUL or in DONE SHALL discard the pending operation; no out_valid pulse after release until a new accept.
REQ-032 rst_n deassertion SHALL be synchronised externally; block assumes release meets recovery/removal.

Verification (WIDTH=8)
REQ-033 ADD a=0xFF b=0x01, out_ready=1 -> one cycle later out_valid=1, out=0x00, carry=1, zero=1, ovf=0, neg=0.
REQ-034 SUB a=0x80 b=0x01 -> out=0x7F, carry=0, ovf=1, neg=0; SUB a=0x01 b=0x02 -> out=0xFF, carry=1, neg=1.
REQ-035 SHL a=0x81 b=0x01 -> out=0x02, carry=1; SHR a=0x81 b=0x00 -> out=0x81, carry=0; SHR a=0x81 b=0x0B (amount 3) -> out=0x10, carry=0.
REQ-036 MUL a=0x10 b=0x11 -> in_ready=0 for 8 cycles, out_valid on 9th cycle after accept, out=0x10, carry=1; MUL a=0x0F b=0x03 -> out=0x2D, carry=0.
REQ-037 Backpressure: out_ready=0 for 5 cycles in DONE with operands toggling -> out/flags constant, in_ready=0; then out_ready=1 with in_valid=1 each cycle, 4 ADDs -> 4 results on 4 consecutive cycles, no loss or duplication.
REQ-038 Reset mid-MUL (cycle 4 of 8): rst_n pulsed low -> out_valid=0, out=0 immediately; after release in_ready=1, no stale result appears; randomised 1000-op run against reference model with random out_ready matches all outputs.
